// File: rtl/read_control_logic.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : read_control_logic                                           |
// | Description : Read-side FIFO-to-RAM mover. Reads WORDS words from a normal |
// |               (non-show-ahead) FIFO and writes them to sequential RAM      |
// |               addresses. Optional running checksum: READ_CTRL_CHECKSUM_EN. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module read_control_logic #(
    parameter int WORDS = 256,
    parameter int AW    = 10
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          rdempty_i,
    input  logic [31:0]   data_i,
    output logic          rdreq_o,
    output logic [AW-1:0] addr_o,
    output logic [31:0]   data_o,
    output logic          we_o,
    output logic          done_o
`ifdef READ_CTRL_CHECKSUM_EN
    ,
    output logic [31:0]   checksum_o
`endif
);

    localparam logic [AW-1:0] c_last_addr = AW'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_STORE = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t r_state;

`ifdef READ_CTRL_CHECKSUM_EN
    logic [31:0] r_checksum;
    assign checksum_o = r_checksum;
`endif

    // Outputs are registered alongside the state transition so each one is a
    // pure decode of the state being entered.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            rdreq_o <= 1'b0;
            we_o    <= 1'b0;
            done_o  <= 1'b0;
            addr_o  <= '0;
            data_o  <= '0;
`ifdef READ_CTRL_CHECKSUM_EN
            r_checksum <= '0;
`endif
        end else begin
            rdreq_o <= 1'b0;
            we_o    <= 1'b0;
            case (r_state)
                S_IDLE, S_WAIT: begin
                    if (!rdempty_i) begin
                        r_state <= S_READ;
                        rdreq_o <= 1'b1;
                    end
                end
                S_READ: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    data_o  <= data_i;
`ifdef READ_CTRL_CHECKSUM_EN
                    r_checksum <= r_checksum + data_i;
`endif
                    r_state <= S_STORE;
                    we_o    <= 1'b1;
                end
                S_STORE: begin
                    if (addr_o == c_last_addr) begin
                        r_state <= S_DONE;
                        done_o  <= 1'b1;
                    end else begin
                        addr_o <= addr_o + 1'b1;
                        // Only request when non-empty was sampled on this edge.
                        if (!rdempty_i) begin
                            r_state <= S_READ;
                            rdreq_o <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    done_o <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    addr_o  <= '0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
